// File: rtl/ifm_out_fsm.sv
// ifm_out_fsm
// Store-and-forward reader for the 10GbE receive path. It waits for a frame's
// status word in the info FIFO, then either streams the frame's beats from the
// data FIFO to the AXI4-Stream master port or discards them if the status
// flags a MAC error. It also keeps wrapping good/bad frame and good byte counts.
module ifm_out_fsm #(
  parameter int C_CNT_W  = 32,
  parameter int C_BYTE_W = 48
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [72:0]         data_fifo_rdata,
  input  logic                data_fifo_empty,
  output logic                data_fifo_rden,
  input  logic [7:0]          info_fifo_rdata,
  input  logic                info_fifo_empty,
  output logic                info_fifo_rden,
  output logic [63:0]         m_axis_tdata,
  output logic [7:0]          m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [C_CNT_W-1:0]  good_frames,
  output logic [C_CNT_W-1:0]  bad_frames,
  output logic [C_BYTE_W-1:0] good_bytes,
  output logic [3:0]          ifm_out_fsm_dbg
);

  localparam logic [1:0] S_IDLE = 2'h0;
  localparam logic [1:0] S_FWD  = 2'h1;
  localparam logic [1:0] S_DROP = 2'h2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       head_last;
  logic       fwd_pop;
  logic       drop_pop;
  logic [3:0] keep_cnt;
  logic       info_rsvd_unused;

  // Number of valid bytes in a beat, 0..8.
  function automatic logic [3:0] count_keep(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, keep[i]};
    end
    return n;
  endfunction

  // The FIFO head is FWFT, so the stream payload is a straight wire from it.
  assign m_axis_tdata    = data_fifo_rdata[63:0];
  assign m_axis_tkeep    = data_fifo_rdata[71:64];
  assign m_axis_tlast    = data_fifo_rdata[72];
  assign head_last       = data_fifo_rdata[72];
  assign keep_cnt        = count_keep(data_fifo_rdata[71:64]);
  assign ifm_out_fsm_dbg = {2'b00, state};

  // Status bits [7:1] are reserved and deliberately ignored.
  assign info_rsvd_unused = ^info_fifo_rdata[7:1];

  // Output decode and next-state selection for the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_nxt      = state;
    info_fifo_rden = 1'b0;
    data_fifo_rden = 1'b0;
    m_axis_tvalid  = 1'b0;
    fwd_pop        = 1'b0;
    drop_pop       = 1'b0;
    case (state)
      S_IDLE: begin
        // Never consume a status word while the FIFOs are being reset with us.
        info_fifo_rden = ~info_fifo_empty & ~sys_rst;
        if (~info_fifo_empty) begin
          state_nxt = info_fifo_rdata[0] ? S_DROP : S_FWD;
        end
      end
      S_FWD: begin
        m_axis_tvalid  = ~data_fifo_empty;
        fwd_pop        = ~data_fifo_empty & m_axis_tready;
        data_fifo_rden = fwd_pop;
        if (fwd_pop & head_last) begin
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        drop_pop       = ~data_fifo_empty;
        data_fifo_rden = drop_pop;
        if (drop_pop & head_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; the unused encoding falls back to idle via state_nxt.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Statistics: bytes per forwarded beat, frames on the tlast pop.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      good_frames <= '0;
      bad_frames  <= '0;
      good_bytes  <= '0;
    end else begin
      if (fwd_pop) begin
        good_bytes <= good_bytes + C_BYTE_W'(keep_cnt);
        if (head_last) begin
          good_frames <= good_frames + C_CNT_W'(1);
        end
      end
      if (drop_pop & head_last) begin
        bad_frames <= bad_frames + C_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifm_out_fsm.sv
// tb_ifm_out_fsm
// Directed per-cycle vectors for the basic good/error frames, hand-written
// sequences for backpressure, back-to-back, starvation and reset, then random
// traffic against a frame-level reference model with a beat scoreboard.
module tb_ifm_out_fsm;

  typedef enum int {M_IDLE, M_FWD, M_DROP} mode_t;

  typedef struct {
    logic        info_empty;
    logic [7:0]  info;
    logic        data_empty;
    logic [72:0] data;
    logic        tready;
    logic        e_info;
    logic        e_pop;
    logic        e_valid;
    logic [3:0]  e_dbg;
    logic [31:0] e_gf;
    logic [31:0] e_bf;
    logic [47:0] e_gb;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty;
  logic        data_fifo_rden;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_empty;
  logic        info_fifo_rden;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] good_frames;
  logic [31:0] bad_frames;
  logic [47:0] good_bytes;
  logic [3:0]  ifm_out_fsm_dbg;

  ifm_out_fsm #(.C_CNT_W(32), .C_BYTE_W(48)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rden  (data_fifo_rden),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rden  (info_fifo_rden),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .good_frames     (good_frames),
    .bad_frames      (bad_frames),
    .good_bytes      (good_bytes),
    .ifm_out_fsm_dbg (ifm_out_fsm_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: FIFO contents, scoreboard of beats owed downstream,
  // which kind of frame is in progress, and the statistics it implies.
  logic [72:0] dq[$];
  logic [7:0]  iq[$];
  logic [72:0] exp_beats[$];
  bit          hold;
  bit          rdy;
  mode_t       mode;
  logic [31:0] m_gf;
  logic [31:0] m_bf;
  logic [47:0] m_gb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ie, input logic [7:0] info, input logic de,
                              input logic [72:0] d, input logic tr, input logic e_info,
                              input logic e_pop, input logic e_valid, input logic [3:0] e_dbg,
                              input logic [31:0] e_gf, input logic [31:0] e_bf,
                              input logic [47:0] e_gb);
    vec_t v;
    v.info_empty = ie;  v.info = info;   v.data_empty = de; v.data = d; v.tready = tr;
    v.e_info = e_info;  v.e_pop = e_pop; v.e_valid = e_valid; v.e_dbg = e_dbg;
    v.e_gf = e_gf;      v.e_bf = e_bf;   v.e_gb = e_gb;
    return v;
  endfunction

  function automatic logic [3:0] mode_dbg(input mode_t m);
    case (m)
      M_FWD:   return 4'h1;
      M_DROP:  return 4'h2;
      default: return 4'h0;
    endcase
  endfunction

  task automatic push_frame(input bit err, input int len);
    logic [72:0] b;
    logic [7:0]  info;
    info    = 8'($urandom);
    info[0] = err;
    for (int i = 0; i < len; i++) begin
      b[63:0]  = {$urandom, $urandom};
      b[71:64] = 8'($urandom);
      b[72]    = (i == len - 1);
      dq.push_back(b);
      if (!err) exp_beats.push_back(b);
    end
    iq.push_back(info);
  endtask

  task automatic drive();
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = (iq.size() != 0) ? iq[0] : 8'h00;
    data_fifo_empty = hold || (dq.size() == 0);
    data_fifo_rdata = (dq.size() != 0) ? dq[0] : 73'h0;
    m_axis_tready   = rdy;
  endtask

  // One clock of FIFO-model traffic: predict, compare, then advance the model.
  task automatic step(output bit popped);
    bit          e_info;
    bit          e_valid;
    bit          e_pop;
    logic [72:0] head;
    logic [72:0] want;
    drive();
    #1;
    e_info  = (mode == M_IDLE) && (iq.size() != 0);
    e_valid = (mode == M_FWD) && !data_fifo_empty;
    e_pop   = e_valid ? rdy : ((mode == M_DROP) && !data_fifo_empty);
    check("info_rden", 64'(info_fifo_rden), 64'(e_info));
    check("data_rden", 64'(data_fifo_rden), 64'(e_pop));
    check("tvalid", 64'(m_axis_tvalid), 64'(e_valid));
    check("dbg", 64'(ifm_out_fsm_dbg), 64'(mode_dbg(mode)));
    check("good_frames", 64'(good_frames), 64'(m_gf));
    check("bad_frames", 64'(bad_frames), 64'(m_bf));
    check("good_bytes", 64'(good_bytes), 64'(m_gb));
    if (m_axis_tvalid && m_axis_tready) begin
      check("beat_owed", 64'(exp_beats.size() != 0), 64'(1));
      if (exp_beats.size() != 0) begin
        want = exp_beats.pop_front();
        check("beat_tdata", m_axis_tdata, want[63:0]);
        check("beat_tkeep", 64'(m_axis_tkeep), 64'(want[71:64]));
        check("beat_tlast", 64'(m_axis_tlast), 64'(want[72]));
      end
    end
    @(posedge sys_clk);
    #1;
    popped = e_pop;
    if (e_info) begin
      mode = iq[0][0] ? M_DROP : M_FWD;
      void'(iq.pop_front());
    end else if (e_pop) begin
      head = dq.pop_front();
      if (mode == M_FWD) m_gb = m_gb + 48'($countones(head[71:64]));
      if (head[72]) begin
        if (mode == M_FWD) m_gf = m_gf + 32'd1;
        else               m_bf = m_bf + 32'd1;
        mode = M_IDLE;
      end
    end
  endtask

  task automatic drain(input int budget, output int cycles);
    bit p;
    cycles = 0;
    while ((iq.size() != 0 || dq.size() != 0 || mode != M_IDLE) && cycles < budget) begin
      step(p);
      cycles++;
    end
    check("drain_done", 64'(iq.size() + dq.size()), 64'(0));
  endtask

  initial begin
    vec_t        vt[10];
    bit          popped;
    int          pops;
    int          cyc;
    logic [31:0] gf0;
    logic [31:0] bf0;
    logic [72:0] b0, b1, b2, e0, e1, e2, e3;

    hold = 1'b0; rdy = 1'b1; mode = M_IDLE;
    m_gf = '0; m_bf = '0; m_gb = '0;

    // Reset with a status word waiting: nothing may be popped or driven.
    sys_rst = 1'b0;
    info_fifo_empty = 1'b0; info_fifo_rdata = 8'h00;
    data_fifo_empty = 1'b0; data_fifo_rdata = 73'h0; m_axis_tready = 1'b1;
    #1 sys_rst = 1'b1;
    #1;
    check("rst info_rden", 64'(info_fifo_rden), 64'(0));
    check("rst data_rden", 64'(data_fifo_rden), 64'(0));
    check("rst tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst dbg", 64'(ifm_out_fsm_dbg), 64'(0));
    check("rst good_frames", 64'(good_frames), 64'(0));
    check("rst bad_frames", 64'(bad_frames), 64'(0));
    check("rst good_bytes", 64'(good_bytes), 64'(0));
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // Good 3-beat frame (20 bytes) then a 4-beat error frame, one idle cycle apart.
    b0 = {1'b0, 8'hFF, 64'h0011_2233_4455_6677};
    b1 = {1'b0, 8'hFF, 64'h8899_AABB_CCDD_EEFF};
    b2 = {1'b1, 8'h0F, 64'h0123_4567_89AB_CDEF};
    e0 = {1'b0, 8'hFF, 64'hDEAD_0000_0000_0000};
    e1 = {1'b0, 8'h03, 64'hDEAD_0000_0000_0001};
    e2 = {1'b0, 8'hFF, 64'hDEAD_0000_0000_0002};
    e3 = {1'b1, 8'h01, 64'hDEAD_0000_0000_0003};
    vt[0] = mk(1'b0, 8'h00, 1'b0, b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 48'd0);
    vt[1] = mk(1'b1, 8'h00, 1'b0, b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 32'd0, 32'd0, 48'd0);
    vt[2] = mk(1'b1, 8'h00, 1'b0, b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 32'd0, 32'd0, 48'd8);
    vt[3] = mk(1'b1, 8'h00, 1'b0, b2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 32'd0, 32'd0, 48'd16);
    vt[4] = mk(1'b0, 8'hA5, 1'b0, e0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'd1, 32'd0, 48'd20);
    vt[5] = mk(1'b1, 8'h00, 1'b0, e0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 32'd1, 32'd0, 48'd20);
    vt[6] = mk(1'b1, 8'h00, 1'b0, e1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 32'd1, 32'd0, 48'd20);
    vt[7] = mk(1'b1, 8'h00, 1'b0, e2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 32'd1, 32'd0, 48'd20);
    vt[8] = mk(1'b1, 8'h00, 1'b0, e3, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 32'd1, 32'd0, 48'd20);
    vt[9] = mk(1'b1, 8'h00, 1'b1, e3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd1, 32'd1, 48'd20);
    foreach (vt[i]) begin
      info_fifo_empty = vt[i].info_empty;
      info_fifo_rdata = vt[i].info;
      data_fifo_empty = vt[i].data_empty;
      data_fifo_rdata = vt[i].data;
      m_axis_tready   = vt[i].tready;
      #1;
      check($sformatf("v%0d info_rden", i), 64'(info_fifo_rden), 64'(vt[i].e_info));
      check($sformatf("v%0d data_rden", i), 64'(data_fifo_rden), 64'(vt[i].e_pop));
      check($sformatf("v%0d tvalid", i), 64'(m_axis_tvalid), 64'(vt[i].e_valid));
      check($sformatf("v%0d dbg", i), 64'(ifm_out_fsm_dbg), 64'(vt[i].e_dbg));
      check($sformatf("v%0d good_frames", i), 64'(good_frames), 64'(vt[i].e_gf));
      check($sformatf("v%0d bad_frames", i), 64'(bad_frames), 64'(vt[i].e_bf));
      check($sformatf("v%0d good_bytes", i), 64'(good_bytes), 64'(vt[i].e_gb));
      if (vt[i].e_valid) begin
        check($sformatf("v%0d tdata", i), m_axis_tdata, vt[i].data[63:0]);
        check($sformatf("v%0d tkeep", i), 64'(m_axis_tkeep), 64'(vt[i].data[71:64]));
        check($sformatf("v%0d tlast", i), 64'(m_axis_tlast), 64'(vt[i].data[72]));
      end
      @(posedge sys_clk);
      #1;
    end
    m_gf = 32'd1; m_bf = 32'd1; m_gb = 48'd20; mode = M_IDLE;

    // Backpressure: 2-beat good frame, tready 0,1,0,0,1 after the info pop.
    gf0 = m_gf;
    push_frame(1'b0, 2);
    rdy = 1'b1;
    step(popped);
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      rdy = (i == 1 || i == 4);
      step(popped);
      if (popped) pops++;
    end
    check("bp pops", 64'(pops), 64'(2));
    check("bp good_frames", 64'(good_frames), 64'(gf0 + 32'd1));

    // Back-to-back good(2), bad(1), good(1): 4 beats + 3 status cycles.
    gf0 = good_frames; bf0 = bad_frames; rdy = 1'b1;
    push_frame(1'b0, 2); push_frame(1'b1, 1); push_frame(1'b0, 1);
    drain(40, cyc);
    check("b2b cycles", 64'(cyc), 64'(7));
    check("b2b good_frames", 64'(good_frames), 64'(gf0 + 32'd2));
    check("b2b bad_frames", 64'(bad_frames), 64'(bf0 + 32'd1));

    // Starved: status present, data withheld for 5 cycles.
    push_frame(1'b0, 3);
    hold = 1'b1;
    step(popped);
    for (int i = 0; i < 5; i++) step(popped);
    hold = 1'b0;
    drain(20, cyc);

    // Reset during beat 2 of a 4-beat good frame, another status word queued.
    push_frame(1'b0, 4); push_frame(1'b0, 1);
    step(popped);
    step(popped);
    drive();
    sys_rst = 1'b1;
    #1;
    check("mrst info_rden", 64'(info_fifo_rden), 64'(0));
    check("mrst data_rden", 64'(data_fifo_rden), 64'(0));
    check("mrst tvalid", 64'(m_axis_tvalid), 64'(0));
    check("mrst dbg", 64'(ifm_out_fsm_dbg), 64'(0));
    check("mrst good_frames", 64'(good_frames), 64'(0));
    check("mrst bad_frames", 64'(bad_frames), 64'(0));
    check("mrst good_bytes", 64'(good_bytes), 64'(0));
    dq.delete(); iq.delete(); exp_beats.delete();
    mode = M_IDLE; m_gf = '0; m_bf = '0; m_gb = '0;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(popped);

    // Random traffic with random backpressure and occasional starvation.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0 && iq.size() < 4) begin
        push_frame($urandom_range(0, 3) == 0, $urandom_range(1, 6));
      end
      rdy  = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 7) == 0);
      step(popped);
    end
    rdy = 1'b1; hold = 1'b0;
    drain(300, cyc);
    check("rand beats_left", 64'(exp_beats.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
